full_adder_bist: RTL and testbench
==================================

# full_adder_bist

Built-in self-test engine for the full-adder user project. It acts as the stimulus/response end of the adder's interface. It drives {a, b, cin} through all eight input combinations, waits a programmable settle time, and checks sum/cout against an internal model. It reports pass/fail, a saturating mismatch count and the first failing vector, so the adder can be checked on silicon without an external bench.

## Interface

Parameters:
- SETTLE_CYCLES, 1: cycles each vector is held before it is checked; legal range 1..15.
- LOOPS, 1: number of full 8-vector sweeps per run; legal range 1..255.

Ports:
- clk  in  1  system clock; one clock domain; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  enable; while low, all state and outputs freeze.
- start  in  1  run request; sampled only in IDLE or DONE with ena=1.
- fa_a  out  1  operand a to the adder under test.
- fa_b  out  1  operand b to the adder under test.
- fa_cin  out  1  carry-in to the adder under test.
- fa_sum  in  1  sum returned by the adder under test.
- fa_cout  in  1  carry-out returned by the adder under test.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  4  number of mismatching vectors, saturating at 15.
- fail_seen  out  1  set when the first mismatch of a run is detected.
- fail_vec  out  3  {a,b,cin} of the first mismatching vector in the run.

## Operation

- Vector index v is a 3-bit counter, applied in order 0..7. Mapping: {fa_a, fa_b, fa_cin} = v.
- Expected response: sum = a^b^cin; cout = (a&b)|(a&cin)|(b&cin).
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE -> DRIVE on start & ena. On the same edge: v=0, loop counter=0, err_count=0, fail_seen=0, fail_vec=0, done=0.
- DRIVE: fa_* = v. The settle counter counts SETTLE_CYCLES cycles, then the FSM moves to CHECK.
- CHECK takes one cycle. It compares fa_sum and fa_cout against the model for the v still being driven.
  - If either output mismatches, err_count increments (held at 15 once reached).
  - On the first mismatch of the run, fail_seen is set and fail_vec captures v.
  - A vector with both outputs wrong counts once.
- CHECK exit:
  - If v != 7: v increments, then DRIVE.
  - If v == 7 and the loop counter != LOOPS-1: v wraps to 0, the loop counter increments, then DRIVE.
  - Otherwise the FSM moves to DONE.
- DONE: done=1 and busy=0. fa_* hold the last vector (3'b111). Results hold. start & ena restarts the run exactly as from IDLE.
- busy = (state == DRIVE or CHECK).
- start while busy is ignored.
- ena=0 freezes the FSM, all counters and all outputs; the run resumes on the first cycle ena=1.
- rst_n=0 at any clock edge, including mid-run, takes effect on that edge: state IDLE, all outputs and counters 0.

## Timing

- Reset values: fa_a=fa_b=fa_cin=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, fail_vec=0.
- All outputs are registered. The edge that accepts start makes busy=1 and drives vector 0.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE plus 1 in CHECK.
- The adder response is sampled at the CHECK edge, so SETTLE_CYCLES is the minimum combinational settle time allowed to the adder.
- Run length: LOOPS*8*(SETTLE_CYCLES+1) cycles from the accepting edge until the edge that raises done. busy falls on that same edge.
- Each cycle with ena=0 during a run extends the run by exactly one cycle.

## Test plan

- Golden adder, SETTLE=1, LOOPS=1, start pulse -> fa_* steps 0..7, each vector held 2 cycles. done rises 16 cycles after accept; pass=1, err_count=0, fail_seen=0.
- Adder with fa_sum stuck at 0, LOOPS=1 -> err_count=4 (vectors 1, 2, 4, 7), fail_seen=1, fail_vec=3'b001, pass=0.
- Same fault with LOOPS=2 -> err_count=8. Then a restart with the golden adder -> err_count=0, pass=1.
- Both outputs inverted, LOOPS=4 -> err_count saturates at 15, fail_vec=3'b000, done after 64 cycles.
- Golden adder, ena=0 for 5 cycles mid-run -> outputs frozen during the gap; done rises at cycle 21 instead of 16. A start pulse while busy has no effect.
- rst_n=0 for one edge mid-run -> next cycle busy=0, done=0, fa_*=0, err_count=0. A fresh start then completes normally.

Source files
------------

// File: rtl/full_adder_bist.sv
// Built-in self-test engine for the full-adder user project.
// Sweeps all eight {a,b,cin} vectors, checks sum/cout and logs the first failure.
module full_adder_bist #(
   parameter int SETTLE_CYCLES = 1,
   parameter int LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   output logic       fa_a,
   output logic       fa_b,
   output logic       fa_cin,
   input  logic       fa_sum,
   input  logic       fa_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_seen,
   output logic [2:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK,
      DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

   state_t     state, state_n;
   logic [2:0] vec, vec_n;
   logic [7:0] loop_cnt, loop_n;
   logic [3:0] settle, settle_n;
   logic [3:0] err_q, err_n;
   logic       fail_q, fail_n;
   logic [2:0] fvec_q, fvec_n;
   logic       busy_q, busy_n;
   logic       done_q, done_n;
   logic       pass_q, pass_n;

   logic exp_sum, exp_cout, mismatch;

   // Reference model for the vector currently on the adder inputs
   always_comb begin
      exp_sum  = vec[2] ^ vec[1] ^ vec[0];
      exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
      mismatch = (fa_sum != exp_sum) || (fa_cout != exp_cout);
   end

   always_comb begin
      state_n  = state;
      vec_n    = vec;
      loop_n   = loop_cnt;
      settle_n = settle;
      err_n    = err_q;
      fail_n   = fail_q;
      fvec_n   = fvec_q;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n  = DRIVE;
               vec_n    = 3'd0;
               loop_n   = 8'd0;
               settle_n = 4'd0;
               err_n    = 4'd0;
               fail_n   = 1'b0;
               fvec_n   = 3'd0;
            end
         end
         DRIVE: begin
            if (settle == SETTLE_LAST) begin
               state_n  = CHECK;
               settle_n = 4'd0;
            end else begin
               settle_n = settle + 4'd1;
            end
         end
         CHECK: begin
            if (mismatch) begin
               if (err_q != 4'd15) err_n = err_q + 4'd1;
               if (!fail_q) begin
                  fail_n = 1'b1;
                  fvec_n = vec;
               end
            end
            if (vec != 3'd7) begin
               vec_n   = vec + 3'd1;
               state_n = DRIVE;
            end else if (loop_cnt != LOOP_LAST) begin
               vec_n   = 3'd0;
               loop_n  = loop_cnt + 8'd1;
               state_n = DRIVE;
            end else begin
               state_n = DONE;
            end
         end
      endcase
      busy_n = (state_n == DRIVE) || (state_n == CHECK);
      done_n = (state_n == DONE);
      pass_n = done_n && (err_n == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         vec      <= 3'd0;
         loop_cnt <= 8'd0;
         settle   <= 4'd0;
         err_q    <= 4'd0;
         fail_q   <= 1'b0;
         fvec_q   <= 3'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else if (ena) begin
         state    <= state_n;
         vec      <= vec_n;
         loop_cnt <= loop_n;
         settle   <= settle_n;
         err_q    <= err_n;
         fail_q   <= fail_n;
         fvec_q   <= fvec_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         pass_q   <= pass_n;
      end
   end

   assign {fa_a, fa_b, fa_cin} = vec;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_seen = fail_q;
   assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench for full_adder_bist: golden and faulty adders,
// multi-loop runs, enable gaps and mid-run reset.
module tb_full_adder_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
   int   fault = 0;
   int   checks = 0;
   int   errors = 0;

   logic a1, b1, c1, s1, co1, busy1, done1, pass1, fs1;
   logic a2, b2, c2, s2, co2, busy2, done2, pass2, fs2;
   logic a4, b4, c4, s4, co4, busy4, done4, pass4, fs4;
   logic [3:0] err1, err2, err4;
   logic [2:0] fv1, fv2, fv4;

   always #5 clk = ~clk;

   // Adder under test: 0 golden, 1 sum stuck at 0, 2 both outputs inverted
   function automatic logic [1:0] resp(input int mode, input logic a,
                                       input logic b, input logic c);
      logic s, co;
      s  = a ^ b ^ c;
      co = (a & b) | (a & c) | (b & c);
      if (mode == 1) s = 1'b0;
      if (mode == 2) begin
         s  = ~s;
         co = ~co;
      end
      return {s, co};
   endfunction

   assign {s1, co1} = resp(fault, a1, b1, c1);
   assign {s2, co2} = resp(fault, a2, b2, c2);
   assign {s4, co4} = resp(fault, a4, b4, c4);

   full_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1),
      .fa_a(a1), .fa_b(b1), .fa_cin(c1), .fa_sum(s1), .fa_cout(co1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_seen(fs1), .fail_vec(fv1)
   );

   full_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2),
      .fa_a(a2), .fa_b(b2), .fa_cin(c2), .fa_sum(s2), .fa_cout(co2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_seen(fs2), .fail_vec(fv2)
   );

   full_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start4),
      .fa_a(a4), .fa_b(b4), .fa_cin(c4), .fa_sum(s4), .fa_cout(co4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .fail_seen(fs4), .fail_vec(fv4)
   );

   function automatic logic dsel(input int which);
      if (which == 2) return done2;
      if (which == 4) return done4;
      return done1;
   endfunction

   // Leaves the bench at the negedge just after the accepting edge
   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 1) start1 = 1'b1;
      if (which == 2) start2 = 1'b1;
      if (which == 4) start4 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int limit, output int cycles);
      cycles = 0;
      while (!dsel(which) && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({a1, b1, c1} !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
          pass1 !== 1'b0 || err1 !== 4'd0 || fs1 !== 1'b0 || fv1 !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: got fa=%b busy=%b done=%b pass=%b err=%0d fs=%b fv=%b, want all 0",
                  {a1, b1, c1}, busy1, done1, pass1, err1, fs1, fv1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || err4 !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b err=%0d, want 0 0 0",
                  busy4, done4, err4);
      end
   endtask

   task automatic test_golden;
      logic [2:0] want;
      fault = 0;
      pulse_start(1);
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL golden_accept: got busy=%b done=%b, want 1 0", busy1, done1);
      end
      for (int k = 0; k < 16; k++) begin
         want = 3'(k / 2);
         checks++;
         if ({a1, b1, c1} !== want || done1 !== 1'b0) begin
            errors++;
            $display("FAIL golden_step%0d: got fa=%b done=%b, want fa=%b done=0",
                     k, {a1, b1, c1}, done1, want);
         end
         @(negedge clk);
      end
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 ||
          err1 !== 4'd0 || fs1 !== 1'b0 || {a1, b1, c1} !== 3'b111) begin
         errors++;
         $display("FAIL golden_done: got done=%b busy=%b pass=%b err=%0d fs=%b fa=%b, want 1 0 1 0 0 111",
                  done1, busy1, pass1, err1, fs1, {a1, b1, c1});
      end
   endtask

   task automatic test_sum_stuck;
      int cyc;
      fault = 1;
      pulse_start(1);
      wait_done(1, 40, cyc);
      checks++;
      if (cyc !== 16) begin
         errors++;
         $display("FAIL stuck_len: got %0d cycles, want 16", cyc);
      end
      checks++;
      if (err1 !== 4'd4 || fs1 !== 1'b1 || fv1 !== 3'b001 || pass1 !== 1'b0) begin
         errors++;
         $display("FAIL stuck_result: got err=%0d fs=%b fv=%b pass=%b, want 4 1 001 0",
                  err1, fs1, fv1, pass1);
      end
   endtask

   task automatic test_loops2;
      int cyc;
      fault = 1;
      pulse_start(2);
      wait_done(2, 60, cyc);
      checks++;
      if (cyc !== 32) begin
         errors++;
         $display("FAIL loops2_len: got %0d cycles, want 32", cyc);
      end
      checks++;
      if (err2 !== 4'd8 || fv2 !== 3'b001 || pass2 !== 1'b0) begin
         errors++;
         $display("FAIL loops2_result: got err=%0d fv=%b pass=%b, want 8 001 0",
                  err2, fv2, pass2);
      end
      fault = 0;
      pulse_start(2);
      checks++;
      if (err2 !== 4'd0 || done2 !== 1'b0 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL restart_clear: got err=%0d done=%b busy=%b, want 0 0 1",
                  err2, done2, busy2);
      end
      wait_done(2, 60, cyc);
      checks++;
      if (cyc !== 32 || err2 !== 4'd0 || pass2 !== 1'b1 || fs2 !== 1'b0) begin
         errors++;
         $display("FAIL restart_golden: got cyc=%0d err=%0d pass=%b fs=%b, want 32 0 1 0",
                  cyc, err2, pass2, fs2);
      end
   endtask

   task automatic test_saturate;
      int cyc;
      fault = 2;
      pulse_start(4);
      wait_done(4, 100, cyc);
      checks++;
      if (cyc !== 64) begin
         errors++;
         $display("FAIL sat_len: got %0d cycles, want 64", cyc);
      end
      checks++;
      if (err4 !== 4'd15 || fs4 !== 1'b1 || fv4 !== 3'b000 || pass4 !== 1'b0) begin
         errors++;
         $display("FAIL sat_result: got err=%0d fs=%b fv=%b pass=%b, want 15 1 000 0",
                  err4, fs4, fv4, pass4);
      end
   endtask

   task automatic test_ena_gap;
      logic [2:0] snap_fa;
      logic       snap_busy;
      int         k;
      fault = 0;
      pulse_start(1);
      repeat (5) @(negedge clk);
      snap_fa   = {a1, b1, c1};
      snap_busy = busy1;
      checks++;
      if (snap_fa !== 3'd2 || snap_busy !== 1'b1) begin
         errors++;
         $display("FAIL gap_pre: got fa=%b busy=%b, want 010 1", snap_fa, snap_busy);
      end
      ena = 1'b0;
      for (int i = 6; i <= 10; i++) begin
         @(negedge clk);
         checks++;
         if ({a1, b1, c1} !== 3'd2 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL gap_frozen%0d: got fa=%b busy=%b done=%b, want 010 1 0",
                     i, {a1, b1, c1}, busy1, done1);
         end
      end
      ena = 1'b1;
      k = 10;
      @(negedge clk);
      k++;
      start1 = 1'b1;
      @(negedge clk);
      k++;
      start1 = 1'b0;
      while (!done1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k !== 21 || pass1 !== 1'b1 || err1 !== 4'd0) begin
         errors++;
         $display("FAIL gap_done: got cycle=%0d pass=%b err=%0d, want 21 1 0",
                  k, pass1, err1);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      fault = 1;
      pulse_start(1);
      repeat (7) @(negedge clk);
      checks++;
      if (err1 !== 4'd2 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: got err=%0d busy=%b, want 2 1", err1, busy1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || {a1, b1, c1} !== 3'd0 ||
          err1 !== 4'd0 || fs1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b done=%b fa=%b err=%0d fs=%b, want all 0",
                  busy1, done1, {a1, b1, c1}, err1, fs1);
      end
      fault = 0;
      pulse_start(1);
      wait_done(1, 40, cyc);
      checks++;
      if (cyc !== 16 || pass1 !== 1'b1 || err1 !== 4'd0) begin
         errors++;
         $display("FAIL mid_rerun: got cyc=%0d pass=%b err=%0d, want 16 1 0",
                  cyc, pass1, err1);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_sum_stuck();
      test_loops2();
      test_saturate();
      test_ena_gap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
